// File: rtl/writeback_stage_pkg.sv
// Shared opcode, flag-index and state definitions for the writeback stage.
// No logic; imported by the stage and its memory-port controller.
package writeback_stage_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_AND    = 4'h2;
    localparam logic [3:0] OP_ORR    = 4'h3;
    localparam logic [3:0] OP_EOR    = 4'h4;
    localparam logic [3:0] OP_LSL    = 4'h5;
    localparam logic [3:0] OP_LSR    = 4'h6;
    localparam logic [3:0] OP_MOVREG = 4'h7;
    localparam logic [3:0] OP_CMP    = 4'h8;
    localparam logic [3:0] OP_LDR    = 4'h9;
    localparam logic [3:0] OP_STR    = 4'hA;
    localparam logic [3:0] OP_NOP    = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_LDWB = 2'd2
    } wb_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'hB) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/mem_port_ctrl.sv
// Single-outstanding memory handshake: latches request, holds mem_req until ack or timeout.
// Request visible the cycle after start; done/timeout are combinational on the closing edge.
module mem_port_ctrl
    import writeback_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_ADDR_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [31:0]           rdata_o,
    output logic [REG_ADDR_W-1:0] rd_o
);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic                  req_q,   req_d;
    logic                  we_q,    we_d;
    logic [31:0]           addr_q,  addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [REG_ADDR_W-1:0] rd_q,    rd_d;
    logic [7:0]            cnt_q,   cnt_d;

    // An ack on the expiry edge wins over the timeout.
    assign done_o    = req_q & mem_ack_i;
    assign timeout_o = req_q & ~mem_ack_i & (cnt_q == TMO_LAST);

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            req_d   = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = we_i ? wdata_i : 32'd0;
            rd_d    = rd_i;
            cnt_d   = 8'd0;
        end else if (req_q) begin
            if (mem_ack_i) begin
                req_d   = 1'b0;
                rdata_d = mem_rdata_i;
            end else if (timeout_o) begin
                req_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            rd_q    <= '0;
            cnt_q   <= 8'd0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign rd_o        = rd_q;

endmodule

// File: rtl/writeback_stage.sv
// ALU writeback stage: owns NZCV, drives register-file write port, runs LDR/STR handshake.
// ALU ops write back one cycle after accept at 1/cycle; memory ops drop in_ready until done.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_ADDR_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            opcode,
    input  logic                  sbit,
    input  logic [31:0]           alu_result,
    input  logic [3:0]            alu_flags,
    input  logic [31:0]           store_data,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic [3:0]            flags,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [31:0]           wb_data,
    output logic                  illegal_op,
    output logic                  mem_err
);

    wb_state_e state_q, state_d;

    logic                  accept;
    logic                  is_mem_op;
    logic                  mem_start;
    logic                  mem_done;
    logic                  mem_timeout;
    logic [31:0]           ld_data;
    logic [REG_ADDR_W-1:0] ld_rd;

    logic [3:0]            flags_q,   flags_d;
    logic                  wb_alu_q,  wb_alu_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  illegal_q, illegal_d;
    logic                  mem_err_q, mem_err_d;

    // Gated by reset so nothing is offered upstream while held in reset.
    assign in_ready  = reset & (state_q == ST_IDLE);
    assign accept    = in_valid & in_ready;
    assign is_mem_op = (opcode == OP_LDR) || (opcode == OP_STR);
    assign mem_start = accept & is_mem_op;

    mem_port_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .REG_ADDR_W  (REG_ADDR_W)
    ) u_mem_port_ctrl (
        .clk         (clk),
        .reset       (reset),
        .start_i     (mem_start),
        .we_i        (opcode == OP_STR),
        .addr_i      (alu_result),
        .wdata_i     (store_data),
        .rd_i        (rd),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .done_o      (mem_done),
        .timeout_o   (mem_timeout),
        .rdata_o     (ld_data),
        .rd_o        (ld_rd)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (mem_start) state_d = ST_MEM;
            ST_MEM: begin
                if (mem_done) begin
                    state_d = mem_we ? ST_IDLE : ST_LDWB;
                end else if (mem_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LDWB: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flags_d   = flags_q;
        wb_alu_d  = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        illegal_d = 1'b0;
        mem_err_d = mem_err_q | mem_timeout;
        if (accept) begin
            if (is_alu_op(opcode)) begin
                wb_alu_d  = 1'b1;
                wb_addr_d = rd;
                wb_data_d = alu_result;
                if (sbit) flags_d = alu_flags;
            end else if (opcode == OP_CMP) begin
                flags_d = alu_result[3:0];
            end else if (is_illegal_op(opcode)) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            flags_q   <= 4'b0000;
            wb_alu_q  <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= 32'd0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            wb_alu_q  <= wb_alu_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Load writeback shares the port; LDWB never overlaps an ALU writeback.
    assign wb_en      = wb_alu_q | (state_q == ST_LDWB);
    assign wb_addr    = (state_q == ST_LDWB) ? ld_rd   : wb_addr_q;
    assign wb_data    = (state_q == ST_LDWB) ? ld_data : wb_data_q;
    assign flags      = flags_q;
    assign illegal_op = illegal_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: scenario tasks plus a writeback scoreboard.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int TMO = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset, in_valid, sbit, mem_ack;
    logic [3:0]    opcode, alu_flags;
    logic [31:0]   alu_result, store_data, mem_rdata;
    logic [AW-1:0] rd;
    logic          in_ready, mem_req, mem_we, wb_en, illegal_op, mem_err;
    logic [3:0]    flags;
    logic [31:0]   mem_addr, mem_wdata, wb_data;
    logic [AW-1:0] wb_addr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wb_t;

    wb_t exp_q[$];
    wb_t exp_wb;

    always #5 clk = ~clk;

    writeback_stage #(.MEM_TIMEOUT(TMO), .REG_ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .sbit       (sbit),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .store_data (store_data),
        .rd         (rd),
        .flags      (flags),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .illegal_op (illegal_op),
        .mem_err    (mem_err)
    );

    // Scoreboard: every writeback strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b1 && wb_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, required no writeback", wb_addr, wb_data);
            end else begin
                exp_wb = exp_q.pop_front();
                if (wb_addr !== exp_wb.addr || wb_data !== exp_wb.data) begin
                    errors++;
                    $display("FAIL wb_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             wb_addr, wb_data, exp_wb.addr, exp_wb.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid   = 1'b0;
        opcode     = OP_NOP;
        sbit       = 1'b0;
        alu_result = 32'd0;
        alu_flags  = 4'd0;
        store_data = 32'd0;
        rd         = '0;
    endtask

    task automatic drive(input logic [3:0] op, input logic s, input logic [31:0] res,
                         input logic [3:0] fl, input logic [31:0] sd, input logic [AW-1:0] r);
        in_valid   = 1'b1;
        opcode     = op;
        sbit       = s;
        alu_result = res;
        alu_flags  = fl;
        store_data = sd;
        rd         = r;
    endtask

    task automatic expect_wb(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back(wb_t'{addr: a, data: d});
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        idle_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr, wb_data, illegal_op, mem_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h wb_en=%b wb_addr=%0d wb_data=%h ill=%b err=%b, required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr, wb_data, illegal_op, mem_err);
        end
        checks++;
        if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b, required 0000", flags); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_add();
        drive(OP_ADD, 1'b1, 32'h5, 4'b0000, 32'd0, 4'd3);
        expect_wb(4'd3, 32'h5);
        next_edge();
        idle_in();
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b1) begin errors++; $display("FAIL add_wb_en: got %b, required 1", wb_en); end
        checks++;
        if (flags !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b, required 0000", flags); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b, required 1", in_ready); end
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b0) begin errors++; $display("FAIL add_wb_pulse: got %b, required 0", wb_en); end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADD, 1'b1, 32'h11, 4'b0100, 32'd0, 4'd1);
        expect_wb(4'd1, 32'h11);
        next_edge();
        drive(OP_SUB, 1'b0, 32'h22, 4'b1111, 32'd0, 4'd2);
        expect_wb(4'd2, 32'h22);
        @(negedge clk);
        checks++;
        if (flags !== 4'b0100) begin errors++; $display("FAIL preset_flags: got %b, required 0100", flags); end
        next_edge();
        drive(OP_CMP, 1'b0, 32'hFFFF_FFF8, 4'b0001, 32'd0, 4'd5);
        @(negedge clk);
        checks++;
        if (flags !== 4'b0100 || wb_en !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sub_nosbit: got flags=%b wb_en=%b in_ready=%b, required 0100 1 1", flags, wb_en, in_ready);
        end
        next_edge();
        idle_in();
        @(negedge clk);
        checks++;
        if (flags !== 4'b1000 || wb_en !== 1'b0) begin
            errors++;
            $display("FAIL cmp_flags: got flags=%b wb_en=%b, required 1000 0", flags, wb_en);
        end
    endtask

    task automatic test_ldr();
        drive(OP_LDR, 1'b1, 32'h100, 4'b1111, 32'hCAFE_0000, 4'd7);
        expect_wb(4'd7, 32'hDEAD_BEEF);
        expect_wb(4'd9, 32'h99);
        next_edge();
        // Next bundle is held by upstream while the load stalls issue.
        drive(OP_ADD, 1'b1, 32'h99, 4'b0011, 32'd0, 4'd9);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wdata !== 32'd0
                || in_ready !== 1'b0 || flags !== 4'b1000) begin
                errors++;
                $display("FAIL ldr_req_c%0d: got req=%b addr=%h we=%b wdata=%h rdy=%b flags=%b, required 1 100 0 0 0 1000",
                         c, mem_req, mem_addr, mem_we, mem_wdata, in_ready, flags);
            end
            if (c == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
        next_edge();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || wb_en !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ldr_wb_cycle: got req=%b wb_en=%b rdy=%b, required 0 1 0", mem_req, wb_en, in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || wb_en !== 1'b0) begin
            errors++;
            $display("FAIL ldr_release: got rdy=%b wb_en=%b, required 1 0", in_ready, wb_en);
        end
        next_edge();
        idle_in();
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b1 || flags !== 4'b0011) begin
            errors++;
            $display("FAIL held_add: got wb_en=%b flags=%b, required 1 0011", wb_en, flags);
        end
    endtask

    task automatic test_str();
        drive(OP_STR, 1'b1, 32'h200, 4'b0111, 32'h1234_5678, 4'd2);
        next_edge();
        idle_in();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200
                || mem_wdata !== 32'h1234_5678 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL str_req_c%0d: got req=%b we=%b addr=%h wdata=%h rdy=%b, required 1 1 200 12345678 0",
                         c, mem_req, mem_we, mem_addr, mem_wdata, in_ready);
            end
        end
        mem_ack = 1'b1;
        next_edge();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1 || wb_en !== 1'b0 || flags !== 4'b0011) begin
            errors++;
            $display("FAIL str_done: got req=%b rdy=%b wb_en=%b flags=%b, required 0 1 0 0011",
                     mem_req, in_ready, wb_en, flags);
        end
    endtask

    task automatic test_timeout();
        int hi;
        hi = 0;
        drive(OP_LDR, 1'b0, 32'h300, 4'b0000, 32'd0, 4'd4);
        next_edge();
        idle_in();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) hi++;
        end
        checks++;
        if (hi != TMO) begin errors++; $display("FAIL tmo_req_cycles: got %0d, required %0d", hi, TMO); end
        checks++;
        if (mem_err !== 1'b1 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL tmo_state: got err=%b req=%b rdy=%b, required 1 0 1", mem_err, mem_req, in_ready);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        next_edge();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b1 || wb_en !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: got err=%b wb_en=%b rdy=%b, required 1 0 1", mem_err, wb_en, in_ready);
        end
        reset = 1'b0;
        next_edge();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b, required 0", mem_err); end
    endtask

    task automatic test_reset_inflight();
        drive(OP_LDR, 1'b0, 32'h400, 4'b0000, 32'd0, 4'd6);
        next_edge();
        idle_in();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL inflight_req: got %b, required 1", mem_req); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr, wb_data, illegal_op, mem_err, flags, in_ready} !== '0) begin
            errors++;
            $display("FAIL inflight_reset: got req=%b addr=%h wb_en=%b flags=%b ill=%b err=%b rdy=%b, required all 0",
                     mem_req, mem_addr, wb_en, flags, illegal_op, mem_err, in_ready);
        end
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        next_edge();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || wb_en !== 1'b0) begin
            errors++;
            $display("FAIL dropped_req: got req=%b wb_en=%b, required 0 0", mem_req, wb_en);
        end
        drive(4'hC, 1'b1, 32'h0000_000C, 4'b1111, 32'd0, 4'd8);
        next_edge();
        idle_in();
        @(negedge clk);
        checks++;
        if (illegal_op !== 1'b1 || wb_en !== 1'b0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL illegal_pulse: got ill=%b wb_en=%b flags=%b, required 1 0 0000", illegal_op, wb_en, flags);
        end
        @(negedge clk);
        checks++;
        if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_once: got %b, required 0", illegal_op); end
        drive(OP_NOP, 1'b1, 32'hFFFF_FFFF, 4'b1111, 32'd0, 4'd1);
        next_edge();
        idle_in();
        @(negedge clk);
        checks++;
        if (flags !== 4'b0000 || wb_en !== 1'b0 || illegal_op !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL nop_effect: got flags=%b wb_en=%b ill=%b rdy=%b, required 0000 0 0 1",
                     flags, wb_en, illegal_op, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_ldr();
        test_str();
        test_timeout();
        test_reset_inflight();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wb_missing: got %0d writebacks outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
